ysyx_22041071_fetch_queue: RTL
==============================

# ysyx_22041071_fetch_queue

Parametrised instruction-fetch stage that replaces the single-register fetch with a decoupled request/response front end and an in-order instruction queue. It owns the fetch PC and issues pipelined requests to instruction memory, with up to DEPTH requests in flight. Responses are buffered and handed to decode through a valid/ready handshake. A redirect from execute/branch resolution flushes the queue and discards stale in-flight responses. It sits between the PC/branch logic and the ID stage.

## Interface
- ADDR_W, 64, fetch address / PC width
- INS_W, 32, instruction width
- DEPTH, 4, queue entries and maximum requests in flight; power of two, ≥2
- RESET_PC, 64'h8000_0000, first fetch address after reset
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  request address (current fetch PC)
- imem_rsp_valid  in  1  response beat; in order, one per accepted request
- imem_rsp_data  in  INS_W  instruction word
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch PC
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_pc  out  ADDR_W  PC of head instruction
- out_ins  out  INS_W  head instruction
- out_snpc  out  ADDR_W  out_pc + 4

## Operation
- Reset (async assert, sync release): fetch_pc=RESET_PC; queue empty; inflight=0; stale=0; out_valid=0; imem_req_valid=0 while reset_n low. out_pc, out_ins, out_snpc read 0 while the queue is empty.
- Credit: imem_req_valid = (count + inflight < DEPTH) & ~redirect_valid. count and inflight are clog2(DEPTH+1) bits.
- Request handshake (req_valid & req_ready): push fetch_pc into a PC tag FIFO; fetch_pc += 4, modulo 2^ADDR_W; inflight += 1.
- Response with stale > 0: data dropped; stale -= 1; inflight -= 1.
- Response with stale == 0: enqueue {tag PC, data}; inflight -= 1; count += 1.
- Dequeue: on out_valid & out_ready, head is popped; count -= 1.
- Simultaneous enqueue and dequeue: count unchanged. The credit rule guarantees no overflow.
- Redirect: fetch_pc = redirect_pc; queue and PC tag FIFO emptied; count = 0.
  - stale = inflight + (rsp this cycle ? -1 : 0) + (req handshake this cycle ? 1 : 0). Because req_valid is gated by redirect, the request term is always 0.
  - A response or dequeue in the redirect cycle is discarded or ignored.
- Response with inflight == 0 is a protocol error: ignored, and flagged by the bench assertion.

## Timing
- Redirect at cycle N → imem_req_addr = redirect_pc with req_valid at N+1, given credit.
- Response at N → out_valid = 1 with that instruction at N+1; no combinational rsp → out path.
- Dequeue at N → the next entry is visible at N+1, or in the same cycle if the queue is implemented as a registered head: head updates at N+1.
- Sustained throughput is 1 instruction/cycle when memory returns one response per cycle and decode is always ready.
- out_* holds stable while out_valid & ~out_ready.
- Redirect takes priority over every other event in the same cycle.

## Structure
- Shared package constants: RESET_PC default and NOP encoding (32'h0000_0013), for later bubble insertion.
- One sub-module: ysyx_22041071_sync_fifo (WIDTH, DEPTH; push/pop/flush/count; async active-low reset). It is instantiated twice:
  - PC tag FIFO, WIDTH=ADDR_W
  - instruction queue, WIDTH=ADDR_W+INS_W
- Fetch control, credit and stale counters live in the top module. Target size is about 200 lines.

## Test plan
- Reset, memory always ready, 1-cycle response, decode ready → imem_req_addr 0x80000000, 0x80000004, …; out_pc matches in order, one per cycle; out_snpc = out_pc+4.
- Decode stalled (out_ready=0) → after DEPTH=4 requests, req_valid drops; queue holds 4 entries. Release → 4 drained in order and fetch resumes at 0x80000010.
- Three requests in flight, redirect to 0x80001000 → the next three responses are dropped and out_valid stays 0. First delivered out_pc = 0x80001000.
- Redirect in the same cycle as rsp_valid and out_ready → both are discarded; stale = inflight−1; no entry at 0x8000xxxx appears after the redirect.
- Fetch at pc=64'hFFFF_FFFF_FFFF_FFFC → next request address 0; out_snpc = 0.
- reset_n asserted mid-stream with two requests in flight → all outputs return to reset values asynchronously; after release, the first request is 0x80000000.

Source files
------------

// File: rtl/ysyx_22041071_fetch_queue_pkg.sv
// rtl/ysyx_22041071_fetch_queue_pkg.sv - shared constants for the decoupled fetch front end
package ysyx_22041071_fetch_queue_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  // Canonical RISC-V NOP (addi x0, x0, 0), reserved for bubble insertion.
  localparam logic [31:0] NOP_INS          = 32'h0000_0013;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/ysyx_22041071_sync_fifo.sv
// rtl/ysyx_22041071_sync_fifo.sv - power-of-two synchronous FIFO with flush and occupancy count
module ysyx_22041071_sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & (count_q != CW'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the occupancy count guards every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ysyx_22041071_fetch_queue.sv
// rtl/ysyx_22041071_fetch_queue.sv - credit-based pipelined instruction fetch with in-order queue and redirect flush
module ysyx_22041071_fetch_queue
  import ysyx_22041071_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INS_W    = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INS_W-1:0]  imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INS_W-1:0]  out_ins,
  output logic [ADDR_W-1:0] out_snpc
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]       fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           stale_q, stale_d;
  logic [CW-1:0]           q_count, tag_count;
  logic [ADDR_W-1:0]       tag_head;
  logic [ADDR_W+INS_W-1:0] q_head;
  logic                    req_fire, rsp_ok, rsp_live, enq, deq;

  // Credit covers both queued and in-flight entries, so the queue can never overflow.
  assign imem_req_valid = reset_n & ~redirect_valid &
                          (({1'b0, q_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid & imem_req_ready;
  assign rsp_ok   = imem_rsp_valid & (inflight_q != '0);
  assign rsp_live = rsp_ok & (stale_q == '0) & (tag_count != '0);
  assign enq      = rsp_live & ~redirect_valid;
  assign deq      = out_valid & out_ready & ~redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      fetch_pc_d = redirect_pc;
      stale_d    = inflight_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      if (rsp_ok && stale_q != '0) stale_d = stale_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      stale_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

  ysyx_22041071_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (req_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_live),
    .flush_i (redirect_valid),
    .head_o  (tag_head),
    .count_o (tag_count)
  );

  ysyx_22041071_sync_fifo #(.WIDTH(ADDR_W + INS_W), .DEPTH(DEPTH)) u_ins_queue (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (enq),
    .data_i  ({tag_head, imem_rsp_data}),
    .pop_i   (deq),
    .flush_i (redirect_valid),
    .head_o  (q_head),
    .count_o (q_count)
  );

  assign out_valid = (q_count != '0);
  assign out_pc    = out_valid ? q_head[INS_W +: ADDR_W] : '0;
  assign out_ins   = out_valid ? q_head[INS_W-1:0] : '0;
  assign out_snpc  = out_valid ? q_head[INS_W +: ADDR_W] + ADDR_W'(PC_STEP) : '0;

endmodule
